// File: rtl/tcm_dma_pkg.sv
// Shared definitions for the TCM DMA engine: FSM encoding and default sizes.
package tcm_pkg;

    localparam int unsigned ADDR_W_DEF = 13;
    localparam int unsigned LEN_W_DEF  = 14;

    localparam logic [7:0] WR_ALL  = 8'hFF;
    localparam logic [7:0] WR_NONE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/tcm_dma_if.sv
// Command and TCM-port bundle for tcm_dma.
// master: the DMA side (drives the RAM port and status); slave: host + RAM side.
interface tcm_dma_if
    import tcm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_fill;
    logic [ADDR_W-1:0] cmd_src;
    logic [ADDR_W-1:0] cmd_dst;
    logic [LEN_W-1:0]  cmd_len;
    logic [63:0]       cmd_pattern;
    logic [ADDR_W-1:0] ram_addr;
    logic [63:0]       ram_wdata;
    logic [7:0]        ram_wr;
    logic [63:0]       ram_rdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  cmd_valid, cmd_fill, cmd_src, cmd_dst, cmd_len, cmd_pattern, ram_rdata,
        output cmd_ready, ram_addr, ram_wdata, ram_wr, busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_fill, cmd_src, cmd_dst, cmd_len, cmd_pattern, ram_rdata,
        input  cmd_ready, ram_addr, ram_wdata, ram_wr, busy, done, err
    );

endinterface

// File: rtl/tcm_dma.sv
// TCM DMA engine: word copy (read then write, 2 cycles/word) and pattern fill
// (1 cycle/word) over a single-port read-first TCM, addresses wrap modulo 2^ADDR_W.
// Fill mode is compiled in only when TCM_DMA_FILL_EN is defined; otherwise a fill
// command is accepted, touches no memory, and ends with done_o and err_o together.
module tcm_dma
    import tcm_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_fill_i,
    input  logic [ADDR_W-1:0] cmd_src_i,
    input  logic [ADDR_W-1:0] cmd_dst_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic [63:0]       cmd_pattern_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [63:0]       ram_data_o,
    output logic [7:0]        ram_wr_o,
    input  logic [63:0]       ram_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [ADDR_W-1:0] src_r;
    logic [ADDR_W-1:0] dst_r;
    logic [LEN_W-1:0]  rem_r;
    logic              fill_r;
    logic [63:0]       pattern_r;
    logic              err_r;
    logic              accept_s;
    logic              reject_s;
    logic              step_s;

    // Next-state and output decode; reset forces every output low immediately.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        reject_s    = 1'b0;
        step_s      = 1'b0;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        ram_addr_o  = '0;
        ram_data_o  = 64'h0;
        ram_wr_o    = WR_NONE;
        if (rst) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cmd_ready_o = 1'b1;
                    if (cmd_valid_i) begin
                        accept_s = 1'b1;
`ifdef TCM_DMA_FILL_EN
                        reject_s = 1'b0;
`else
                        reject_s = cmd_fill_i;
`endif
                        if (reject_s || (cmd_len_i == '0)) begin
                            state_nxt_s = ST_DONE;
                        end else if (cmd_fill_i) begin
                            state_nxt_s = ST_WR;
                        end else begin
                            state_nxt_s = ST_RD;
                        end
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RD: begin
                    busy_o      = 1'b1;
                    ram_addr_o  = src_r;
                    state_nxt_s = ST_WR;
                end
                ST_WR: begin
                    busy_o     = 1'b1;
                    ram_addr_o = dst_r;
                    ram_data_o = fill_r ? pattern_r : ram_data_i;
                    ram_wr_o   = WR_ALL;
                    step_s     = 1'b1;
                    if (rem_r == LEN_W'(1)) begin
                        state_nxt_s = ST_DONE;
                    end else if (fill_r) begin
                        state_nxt_s = ST_WR;
                    end else begin
                        state_nxt_s = ST_RD;
                    end
                end
                ST_DONE: begin
                    busy_o      = 1'b1;
                    done_o      = 1'b1;
                    err_o       = err_r;
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register plus command latch and inline address/length counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            src_r     <= '0;
            dst_r     <= '0;
            rem_r     <= '0;
            fill_r    <= 1'b0;
            pattern_r <= 64'h0;
            err_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                src_r     <= cmd_src_i;
                dst_r     <= cmd_dst_i;
                rem_r     <= cmd_len_i;
                fill_r    <= cmd_fill_i;
                pattern_r <= cmd_pattern_i;
                err_r     <= reject_s;
            end else if (step_s) begin
                src_r <= src_r + ADDR_W'(1);
                dst_r <= dst_r + ADDR_W'(1);
                rem_r <= rem_r - LEN_W'(1);
            end else begin
                src_r <= src_r;
                dst_r <= dst_r;
                rem_r <= rem_r;
            end
        end
    end

endmodule
